// File: rtl/spi_igress_pkg.sv
// Shared SPI mode encoding and the clock polarity/phase helpers derived from it.
package spi_igress_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  function automatic logic cpol(input spi_mode_t mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input spi_mode_t mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_axis_igress_sync_if.sv
// AXI-Stream bundle carrying received SPI words out of the ingress block.
interface spi_slave_axis_igress_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 8,
  parameter int ID_WIDTH   = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic [DEST_WIDTH-1:0] tdest;
  logic [ID_WIDTH-1:0]   tid;

  modport master (output tdata, tvalid, tuser, tdest, tid, input tready);
  modport slave  (input tdata, tvalid, tuser, tdest, tid, output tready);

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; DEPTH must be a power of two.
module axis_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/spi_slave_axis_igress_sync.sv
// SPI slave receiver oversampled by clk; assembled words leave through an AXIS FIFO.
module spi_slave_axis_igress_sync
  import spi_igress_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SPI_MODE    = 1,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEST_WIDTH  = 8,
  parameter int ID_WIDTH    = 8,
  parameter int AXIS_DEST   = 0,
  parameter int AXIS_SOURCE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spi_clk,
  input  logic                          spi_csn,
  input  logic                          spi_mosi,
  spi_slave_axis_igress_sync_if.master  m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_overrun,
  output logic                          err_partial,
  input  logic                          err_clear
);

  localparam spi_mode_t MODE        = spi_mode_t'(2'(SPI_MODE));
  localparam logic      CPOL        = cpol(MODE);
  localparam logic      SAMPLE_RISE = (cpol(MODE) == cpha(MODE));
  localparam int        SL          = SYNC_STAGES;
  localparam int        CW          = $clog2(DATA_WIDTH);

  logic [SL:0]           clk_sync;
  logic [SL:0]           csn_sync;
  logic [SL:0]           mosi_sync;
  logic                  sclk_rise, sclk_fall, sample_edge;
  logic                  csn_cur, csn_fall, csn_rise;
  logic                  mosi_bit;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  tuser_pend;
  logic                  capture;
  logic [DATA_WIDTH-1:0] word_p1;
  logic                  user_p1;
  logic                  vld_p1;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic                  pop, overrun_evt, partial_evt;

  // Stage 0..SL-1 synchronise, stage SL is the history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= {(SL+1){CPOL}};
      csn_sync  <= '1;
      mosi_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[SL-1:0], spi_clk};
      csn_sync  <= {csn_sync[SL-1:0], spi_csn};
      mosi_sync <= {mosi_sync[SL-1:0], spi_mosi};
    end
  end

  assign sclk_rise   = clk_sync[SL-1] & ~clk_sync[SL];
  assign sclk_fall   = ~clk_sync[SL-1] & clk_sync[SL];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign csn_cur     = csn_sync[SL-1];
  assign csn_fall    = ~csn_sync[SL-1] & csn_sync[SL];
  assign csn_rise    = csn_sync[SL-1] & ~csn_sync[SL];
  // MOSI is taken from the flop aligned with the pre-edge spi_clk level.
  assign mosi_bit    = mosi_sync[SL];

  if (MSB_FIRST != 0) begin : g_msb
    assign shift_nxt = {shift[DATA_WIDTH-2:0], mosi_bit};
  end else begin : g_lsb
    assign shift_nxt = {mosi_bit, shift[DATA_WIDTH-1:1]};
  end

  assign capture     = ~csn_cur & sample_edge & (bit_cnt == CW'(DATA_WIDTH - 1));
  assign partial_evt = csn_rise & (bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      tuser_pend <= 1'b1;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= capture;
      if (csn_cur) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (sample_edge) begin
        shift   <= shift_nxt;
        bit_cnt <= capture ? '0 : bit_cnt + 1'b1;
      end
      if (capture)  tuser_pend <= 1'b0;
      if (csn_fall) tuser_pend <= 1'b1;
    end
  end

  // Stage p1: completed word waits one clk before entering the FIFO.
  always_ff @(posedge clk) begin
    if (capture) begin
      word_p1 <= shift_nxt;
      user_p1 <= tuser_pend;
    end
  end

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .wdata ({user_p1, word_p1}),
    .pop   (m_axis.tready),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis.tvalid = ~fifo_empty;
  assign {m_axis.tuser, m_axis.tdata} = fifo_rdata;
  assign m_axis.tdest  = DEST_WIDTH'(AXIS_DEST);
  assign m_axis.tid    = ID_WIDTH'(AXIS_SOURCE);
  assign pop           = m_axis.tvalid & m_axis.tready;
  assign overrun_evt   = vld_p1 & fifo_full & ~pop;

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overrun <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      err_overrun <= overrun_evt | (err_overrun & ~err_clear);
      err_partial <= partial_evt | (err_partial & ~err_clear);
    end
  end

endmodule

// File: tb/tb_spi_slave_axis_igress_sync.sv
// Directed bench: one 8-bit mode-0 receiver for protocol corners, five 16-bit receivers for modes/bit order.
module tb_spi_slave_axis_igress_sync;
  import spi_igress_pkg::*;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] phase;
  logic [1:0] csn;
  logic [1:0] mosi;
  logic       mosi_l;
  logic       rdy0;
  logic       eclr;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  spi_slave_axis_igress_sync_if #(.DATA_WIDTH(8), .DEST_WIDTH(8), .ID_WIDTH(8)) ax0();
  logic [2:0] lvl0;
  logic       ovr0, par0;
  assign ax0.tready = rdy0;

  spi_slave_axis_igress_sync #(
    .DATA_WIDTH(8), .SPI_MODE(0), .MSB_FIRST(1), .FIFO_DEPTH(4), .SYNC_STAGES(2),
    .DEST_WIDTH(8), .ID_WIDTH(8), .AXIS_DEST(8'h5A), .AXIS_SOURCE(8'hC3)
  ) dut (
    .clk(clk), .rst(rst), .spi_clk(phase[0]), .spi_csn(csn[0]), .spi_mosi(mosi[0]),
    .m_axis(ax0.master), .fifo_level(lvl0), .err_overrun(ovr0), .err_partial(par0),
    .err_clear(eclr)
  );

  logic [15:0] wd [5];
  logic        wv [5];
  logic        wu [5];
  logic        wz [5];

  for (genvar k = 0; k < 5; k++) begin : g_wide
    localparam int   MODE = (k == 4) ? 1 : k;
    localparam logic POL  = (MODE >= 2);
    spi_slave_axis_igress_sync_if #(.DATA_WIDTH(16), .DEST_WIDTH(8), .ID_WIDTH(8)) ax();
    logic [2:0] lvl;
    logic       ovr, par;
    assign ax.tready = 1'b1;
    spi_slave_axis_igress_sync #(
      .DATA_WIDTH(16), .SPI_MODE(MODE), .MSB_FIRST((k == 4) ? 0 : 1), .FIFO_DEPTH(4),
      .SYNC_STAGES(2 + (k % 2)), .DEST_WIDTH(8), .ID_WIDTH(8), .AXIS_DEST(0), .AXIS_SOURCE(0)
    ) u (
      .clk(clk), .rst(rst), .spi_clk(phase[1] ^ POL), .spi_csn(csn[1]),
      .spi_mosi((k == 4) ? mosi_l : mosi[1]), .m_axis(ax.master), .fifo_level(lvl),
      .err_overrun(ovr), .err_partial(par), .err_clear(1'b0)
    );
    assign wd[k] = ax.tdata;
    assign wv[k] = ax.tvalid;
    assign wu[k] = ax.tuser;
    assign wz[k] = |{ax.tdest, ax.tid, lvl, ovr, par};
  end

  logic [8:0]  q0 [$];
  logic [16:0] wlast [5];
  int          wcnt [5];

  initial begin
    for (int k = 0; k < 5; k++) begin
      wcnt[k]  = 0;
      wlast[k] = '0;
    end
    forever begin
      @(negedge clk);
      #2;
      if (ax0.tvalid && rdy0) q0.push_back({ax0.tuser, ax0.tdata});
      for (int k = 0; k < 5; k++) begin
        if (wv[k]) begin
          wlast[k] = {wu[k], wd[k]};
          wcnt[k]++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_q0(input string name, input logic [8:0] exp);
    logic [8:0] w;
    if (q0.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no word received, required 0x%0h", name, exp);
    end else begin
      w = q0.pop_front();
      chk(name, {23'd0, w}, {23'd0, exp});
    end
  endtask

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic frame_begin(input int b);
    csn[b] = 1'b0;
    wait_h();
  endtask

  task automatic frame_end(input int b);
    csn[b] = 1'b1;
    wait_h();
  endtask

  task automatic pulse_clear();
    eclr = 1'b1;
    @(negedge clk);
    eclr = 1'b0;
    @(negedge clk);
  endtask

  // hook 1: latency check on the last leading edge; hook 2: pop coincident with the push.
  task automatic send_bits(input int b, input logic [15:0] v, input int w, input int nb, input int hook);
    for (int i = 0; i < nb; i++) begin
      mosi[b] = v[w-1-i];
      if (b == 1) mosi_l = v[i];
      wait_h();
      phase[b] = 1'b1;
      if (i == w - 1 && hook == 1) begin
        repeat (3) @(posedge clk);
        #1 chk("latency_tvalid_early", {31'd0, ax0.tvalid}, 32'd0);
        @(posedge clk);
        #1 chk("latency_tvalid", {31'd0, ax0.tvalid}, 32'd1);
        @(negedge clk);
      end else if (i == w - 1 && hook == 2) begin
        repeat (3) @(negedge clk);
        rdy0 = 1'b1;
        @(posedge clk);
        #1 chk("full_pushpop_level", {29'd0, lvl0}, 32'd4);
        chk("full_pushpop_overrun", {31'd0, ovr0}, 32'd0);
        @(negedge clk);
        rdy0 = 1'b0;
      end
      wait_h();
      phase[b] = 1'b0;
      wait_h();
    end
  endtask

  typedef struct {
    logic [7:0] val;
    bit         first;
    bit         last;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] val;
    logic [15:0] exp;
  } wvec_t;

  vec_t  tv [6];
  wvec_t wtv [3];

  initial begin
    tv[0] = '{8'hA5, 1'b1, 1'b0, {1'b1, 8'hA5}};
    tv[1] = '{8'h3C, 1'b0, 1'b1, {1'b0, 8'h3C}};
    tv[2] = '{8'h00, 1'b1, 1'b1, {1'b1, 8'h00}};
    tv[3] = '{8'hFF, 1'b1, 1'b0, {1'b1, 8'hFF}};
    tv[4] = '{8'h81, 1'b0, 1'b0, {1'b0, 8'h81}};
    tv[5] = '{8'h7E, 1'b0, 1'b1, {1'b0, 8'h7E}};
    wtv[0] = '{16'h1234, 16'h1234};
    wtv[1] = '{16'h8001, 16'h8001};
    wtv[2] = '{16'h0F5A, 16'h0F5A};

    rst    = 1'b1;
    phase  = 2'b00;
    csn    = 2'b11;
    mosi   = 2'b00;
    mosi_l = 1'b0;
    rdy0   = 1'b1;
    eclr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_tvalid", {31'd0, ax0.tvalid}, 32'd0);
    chk("reset_level", {29'd0, lvl0}, 32'd0);
    chk("reset_overrun", {31'd0, ovr0}, 32'd0);
    chk("reset_partial", {31'd0, par0}, 32'd0);
    chk("tdest_const", {24'd0, ax0.tdest}, 32'h5A);
    chk("tid_const", {24'd0, ax0.tid}, 32'hC3);

    // Frames of words with tready=1; every word also has its push latency checked.
    for (int j = 0; j < 6; j++) begin
      if (tv[j].first) frame_begin(0);
      send_bits(0, {8'd0, tv[j].val}, 8, 8, 1);
      if (tv[j].last) frame_end(0);
      chk_q0($sformatf("frame_word%0d", j), tv[j].exp);
    end

    // Overrun: five words into a four-deep FIFO with the sink stalled.
    rdy0 = 1'b0;
    frame_begin(0);
    for (int i = 1; i <= 5; i++) send_bits(0, 16'(i), 8, 8, 0);
    frame_end(0);
    chk("ovr_level", {29'd0, lvl0}, 32'd4);
    chk("ovr_flag", {31'd0, ovr0}, 32'd1);
    chk("ovr_head_stable", {23'd0, ax0.tuser, ax0.tdata}, {23'd0, 1'b1, 8'h01});
    rdy0 = 1'b1;
    repeat (8) @(negedge clk);
    chk_q0("ovr_drain1", {1'b1, 8'h01});
    chk_q0("ovr_drain2", {1'b0, 8'h02});
    chk_q0("ovr_drain3", {1'b0, 8'h03});
    chk_q0("ovr_drain4", {1'b0, 8'h04});
    chk("ovr_no_fifth", q0.size(), 32'd0);
    chk("ovr_sticky", {31'd0, ovr0}, 32'd1);
    pulse_clear();
    chk("ovr_cleared", {31'd0, ovr0}, 32'd0);

    // Partial word: CSN rises after three bits.
    frame_begin(0);
    send_bits(0, 16'h00E0, 8, 3, 0);
    frame_end(0);
    chk("partial_flag", {31'd0, par0}, 32'd1);
    chk("partial_no_push", {29'd0, lvl0}, 32'd0);
    chk("partial_no_word", q0.size(), 32'd0);
    pulse_clear();
    chk("partial_cleared", {31'd0, par0}, 32'd0);
    frame_begin(0);
    send_bits(0, 16'h0096, 8, 8, 0);
    frame_end(0);
    chk_q0("after_partial_tuser", {1'b1, 8'h96});

    // Reset mid-word with two words buffered.
    rdy0 = 1'b0;
    frame_begin(0);
    send_bits(0, 16'h0011, 8, 8, 0);
    send_bits(0, 16'h0022, 8, 8, 0);
    send_bits(0, 16'h0033, 8, 4, 0);
    chk("prereset_level", {29'd0, lvl0}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_tvalid", {31'd0, ax0.tvalid}, 32'd0);
    chk("midreset_level", {29'd0, lvl0}, 32'd0);
    frame_end(0);
    rdy0 = 1'b1;
    frame_begin(0);
    send_bits(0, 16'h005C, 8, 8, 0);
    send_bits(0, 16'h00C5, 8, 8, 0);
    frame_end(0);
    chk_q0("postreset_word0", {1'b1, 8'h5C});
    chk_q0("postreset_word1", {1'b0, 8'hC5});

    // Full FIFO, sink pops in the very cycle the fifth word is pushed.
    rdy0 = 1'b0;
    frame_begin(0);
    for (int i = 1; i <= 4; i++) send_bits(0, 16'(i), 8, 8, 0);
    chk("full_level", {29'd0, lvl0}, 32'd4);
    send_bits(0, 16'h0005, 8, 8, 2);
    frame_end(0);
    chk("full_pushpop_no_overrun", {31'd0, ovr0}, 32'd0);
    rdy0 = 1'b1;
    repeat (8) @(negedge clk);
    chk_q0("pushpop_word1", {1'b1, 8'h01});
    chk_q0("pushpop_word2", {1'b0, 8'h02});
    chk_q0("pushpop_word3", {1'b0, 8'h03});
    chk_q0("pushpop_word4", {1'b0, 8'h04});
    chk_q0("pushpop_word5", {1'b0, 8'h05});
    chk("pushpop_empty", {29'd0, lvl0}, 32'd0);

    // 16-bit receivers: modes 0..3 MSB first, and mode 1 LSB first.
    for (int j = 0; j < 3; j++) begin
      frame_begin(1);
      send_bits(1, wtv[j].val, 16, 16, 0);
      frame_end(1);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("wide%0d_vec%0d_count", k, j), wcnt[k], j + 1);
        chk($sformatf("wide%0d_vec%0d_word", k, j), {15'd0, wlast[k]}, {15'd0, 1'b1, wtv[j].exp});
      end
    end
    for (int k = 0; k < 5; k++) chk($sformatf("wide%0d_idle", k), {31'd0, wz[k]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
